// File: rtl/mole_game_ctrl.sv
// ============================================================================
// Module   : mole_game_ctrl
// Purpose  : Whack-a-mole game state, mole position, score and round timer.
//            Optional macro MOLE_MISS_PENALTY_EN: a wrong hole costs one point.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mole_game_ctrl #(
    parameter int CLK_FRE        = 27,
    parameter int FRAMES_PER_SEC = 60,
    parameter int GAME_TIME      = 60,
    parameter int MOLE_FRAMES    = 90
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_in,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_en,
    output logic [1:0]  state,
    output logic [3:0]  mole_find,
    output logic [7:0]  mole_score,
    output logic [11:0] left_time
);

    localparam int             c_SEC_W     = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [c_SEC_W-1:0] c_SEC_LAST  = c_SEC_W'(FRAMES_PER_SEC - 1);
    localparam logic [c_SEC_W-1:0] c_SEC_ONE   = c_SEC_W'(1);
    localparam logic [7:0]     c_MOLE_LAST = 8'(MOLE_FRAMES - 1);
    localparam logic [11:0]    c_GAME_TIME = 12'(GAME_TIME);
    localparam logic [15:0]    c_LFSR_SEED = 16'hACE1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PLAY = 2'd1;
    localparam logic [1:0] c_ST_OVER = 2'd2;

    generate
        if (CLK_FRE < 1 || FRAMES_PER_SEC < 1 || GAME_TIME < 1 || GAME_TIME > 4095 ||
            MOLE_FRAMES < 1 || MOLE_FRAMES > 255) begin : g_param_check
            $error("mole_game_ctrl: parameter out of range");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [3:0]         r_mole;
    logic [7:0]         r_score;
    logic [11:0]        r_left_time;
    logic [15:0]        r_lfsr;
    logic               r_vs_d1;
    logic               r_vs_d2;
    logic [c_SEC_W-1:0] r_sec_cnt;
    logic [7:0]         r_mole_cnt;

    logic [15:0] w_lfsr_next;
    logic        w_tick;
    logic        w_is_hole;
    logic [3:0]  w_hole_idx;
    logic        w_start;
    logic        w_hit;
    logic        w_sec_wrap;
    logic        w_mole_wrap;
    logic [3:0]  w_reloc;

    assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    assign w_tick      = r_vs_d1 & ~r_vs_d2;

    // 'A'..'P' have low nibbles 1..F,0 so the hole index is the nibble minus one
    assign w_is_hole   = rx_data_en && (rx_data >= 8'h41) && (rx_data <= 8'h50);
    assign w_hole_idx  = rx_data[3:0] - 4'd1;
    assign w_start     = rx_data_en && (rx_data == 8'h53);
    assign w_hit       = w_is_hole && (w_hole_idx == r_mole);
    assign w_sec_wrap  = w_tick && (r_sec_cnt == c_SEC_LAST);
    assign w_mole_wrap = w_tick && (r_mole_cnt == c_MOLE_LAST);
    assign w_reloc     = (r_lfsr[3:0] == r_mole) ? (r_lfsr[3:0] + 4'd1) : r_lfsr[3:0];

`ifdef MOLE_MISS_PENALTY_EN
    logic w_miss;
    assign w_miss = w_is_hole && (w_hole_idx != r_mole);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_mole      <= 4'd0;
            r_score     <= 8'd0;
            r_left_time <= c_GAME_TIME;
            r_lfsr      <= c_LFSR_SEED;
            r_vs_d1     <= 1'b0;
            r_vs_d2     <= 1'b0;
            r_sec_cnt   <= '0;
            r_mole_cnt  <= 8'd0;
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_vs_d1 <= vs_in;
            r_vs_d2 <= r_vs_d1;
            case (r_state)
                c_ST_PLAY: begin
                    if (w_tick) begin
                        r_sec_cnt <= w_sec_wrap ? '0 : (r_sec_cnt + c_SEC_ONE);
                    end
                    // A hit coinciding with a timeout still relocates only once
                    if (w_hit || w_mole_wrap) begin
                        r_mole_cnt <= 8'd0;
                        r_mole     <= w_reloc;
                    end else if (w_tick) begin
                        r_mole_cnt <= r_mole_cnt + 8'd1;
                    end
                    if (w_hit) begin
                        if (r_score != 8'hFF) begin
                            r_score <= r_score + 8'd1;
                        end
                    end
`ifdef MOLE_MISS_PENALTY_EN
                    else if (w_miss && (r_score != 8'd0)) begin
                        r_score <= r_score - 8'd1;
                    end
`endif
                    if (w_sec_wrap) begin
                        if (r_left_time <= 12'd1) begin
                            r_left_time <= 12'd0;
                            r_state     <= c_ST_OVER;
                        end else begin
                            r_left_time <= r_left_time - 12'd1;
                        end
                    end
                end
                c_ST_IDLE, c_ST_OVER: begin
                    if (w_start) begin
                        r_state     <= c_ST_PLAY;
                        r_score     <= 8'd0;
                        r_left_time <= c_GAME_TIME;
                        r_sec_cnt   <= '0;
                        r_mole_cnt  <= 8'd0;
                        r_mole      <= r_lfsr[3:0];
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign state      = r_state;
    assign mole_find  = r_mole;
    assign mole_score = r_score;
    assign left_time  = r_left_time;

endmodule

`default_nettype wire
